// File: rtl/i_serdes_align_pkg.sv
// i_serdes_align_pkg: shared types and constants for the I_SERDES word-alignment
// controller. Holds the FSM state enum, counter widths and the pattern mask helper.
package i_serdes_align_pkg;

  localparam int MATCH_W = 8;   // consecutive-match counter
  localparam int SLIP_W  = 4;   // bitslips issued in one attempt
  localparam int TIMER_W = 16;  // WAIT_VALID timeout / SETTLE countdown

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VALID,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_ERROR
  } state_e;

  // Keep only the low 'width' bits of the 10-bit pattern. For width=10 the
  // shift wraps to zero and the subtraction yields an all-ones mask.
  function automatic logic [9:0] mask_pattern(input logic [9:0] pat, input int width);
    return pat & ((10'd1 << width) - 10'd1);
  endfunction

endpackage

// File: rtl/i_serdes_align_ctrl_timer.sv
// align_timer: loadable up/down counter with a zero flag. The controller uses
// it counting up as the WAIT_VALID timeout and counting down as the SETTLE delay.
// Ports: clk_i, rst_i (sync, active high), clr_i (to 0), load_i/load_val_i,
//        inc_i, dec_i, cnt_o (current value), zero_o (cnt_o == 0).
// Priority: clear > load > increment > decrement. Both directions saturate.
module align_timer
  import i_serdes_align_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (load_i)                  cnt_d = load_val_i;
    else if (inc_i && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
    else if (dec_i && (cnt_q != '0))  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i_serdes_align_ctrl.sv
// i_serdes_align_ctrl: word-alignment controller for one I_SERDES lane.
// On START it waits for DATA_VALID, compares each valid word with the training
// pattern and pulses BITSLIP_ADJ on every mismatch until MATCH_COUNT consecutive
// matches lock the lane, or the slip budget / WAIT_VALID timeout raises an error.
// Ports: CLK, RST (sync, active high), START (level), Q[WIDTH-1:0], DATA_VALID,
//        BITSLIP_ADJ, ALIGNED, ALIGN_ERROR, BUSY, SLIP_COUNT[3:0]. All outputs registered.
module i_serdes_align_ctrl
  import i_serdes_align_pkg::*;
#(
  parameter int         WIDTH            = 4,
  parameter logic [9:0] TRAINING_PATTERN = 10'h0F3,
  parameter int         MATCH_COUNT      = 8,
  parameter int         MAX_SLIPS        = 10,
  parameter int         SETTLE_CYCLES    = 4,
  parameter int         LOCK_TIMEOUT     = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] Q,
  input  logic             DATA_VALID,
  output logic             BITSLIP_ADJ,
  output logic             ALIGNED,
  output logic             ALIGN_ERROR,
  output logic             BUSY,
  output logic [SLIP_W-1:0] SLIP_COUNT
);

  if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
    $error("i_serdes_align_ctrl: WIDTH must be 3..10");
  end
  if (MATCH_COUNT < 1 || MATCH_COUNT > 255) begin : g_bad_match
    $error("i_serdes_align_ctrl: MATCH_COUNT must be 1..255");
  end
  if (MAX_SLIPS < 1 || MAX_SLIPS > 15) begin : g_bad_slips
    $error("i_serdes_align_ctrl: MAX_SLIPS must be 1..15");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("i_serdes_align_ctrl: SETTLE_CYCLES must be 1..255");
  end
  if (LOCK_TIMEOUT < 0 || LOCK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("i_serdes_align_ctrl: LOCK_TIMEOUT must be 0..65535");
  end

  localparam logic [9:0]         PAT      = mask_pattern(TRAINING_PATTERN, WIDTH);
  localparam logic [MATCH_W-1:0] MC_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_W-1:0]  SLIP_MAX = SLIP_W'(MAX_SLIPS);
  localparam bit                 TO_EN    = (LOCK_TIMEOUT != 0);
  localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
  // SETTLE lasts SETTLE_CYCLES cycles: the timer is loaded one short and the
  // FSM leaves SETTLE in the cycle it reads zero.
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [SLIP_W-1:0]    slip_q, slip_d;
  logic                 tmr_clr, tmr_load, tmr_inc, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0]   tmr_cnt;
  logic [9:0]           q_ext;
  logic                 word_ok;

  always_comb begin
    q_ext = '0;
    q_ext[WIDTH-1:0] = Q;
  end
  assign word_ok = (q_ext == PAT);

  align_timer #(.W(TIMER_W)) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .inc_i      (tmr_inc),
    .dec_i      (tmr_dec),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    slip_d   = slip_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_inc  = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOCKED, ST_ERROR: begin
        if (START) begin
          state_d = ST_WAIT_VALID;
          match_d = '0;
          slip_d  = '0;
          tmr_clr = 1'b1;
        end
      end
      ST_WAIT_VALID: begin
        if (DATA_VALID) begin
          state_d = ST_CHECK;
        end else begin
          tmr_inc = 1'b1;
          if (TO_EN && (tmr_cnt == TO_LAST)) state_d = ST_ERROR;
        end
      end
      ST_CHECK: begin
        if (DATA_VALID) begin
          if (word_ok) begin
            if (match_q == MC_LAST) state_d = ST_LOCKED;
            else                    match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
            state_d = (slip_q == SLIP_MAX) ? ST_ERROR : ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        slip_d   = slip_q + 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
          match_d = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      match_q     <= '0;
      slip_q      <= '0;
      BITSLIP_ADJ <= 1'b0;
      ALIGNED     <= 1'b0;
      ALIGN_ERROR <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      slip_q      <= slip_d;
      BITSLIP_ADJ <= (state_d == ST_SLIP);
      ALIGNED     <= (state_d == ST_LOCKED);
      ALIGN_ERROR <= (state_d == ST_ERROR);
      BUSY        <= (state_d == ST_WAIT_VALID) || (state_d == ST_CHECK) ||
                     (state_d == ST_SLIP) || (state_d == ST_SETTLE);
    end
  end

  assign SLIP_COUNT = slip_q;

endmodule
